// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP controller: TAP state encoding,
// default instruction codes and the default IDCODE.
package jtag_pkg;

   localparam int unsigned TAP_STATE_BITS = 4;

   // Encoding follows the customary 1149.1 state numbering.
   typedef enum logic [TAP_STATE_BITS-1:0] {
      EXIT2_DR         = 4'h0,
      EXIT1_DR         = 4'h1,
      SHIFT_DR         = 4'h2,
      PAUSE_DR         = 4'h3,
      SELECT_IR        = 4'h4,
      UPDATE_DR        = 4'h5,
      CAPTURE_DR       = 4'h6,
      SELECT_DR        = 4'h7,
      EXIT2_IR         = 4'h8,
      EXIT1_IR         = 4'h9,
      SHIFT_IR         = 4'hA,
      PAUSE_IR         = 4'hB,
      RUN_TEST_IDLE    = 4'hC,
      UPDATE_IR        = 4'hD,
      CAPTURE_IR       = 4'hE,
      TEST_LOGIC_RESET = 4'hF
   } tap_state_e;

   localparam int unsigned DEF_IR_BITS        = 4;
   localparam logic [3:0]  DEF_IR_IDCODE      = 4'b0001;
   localparam logic [3:0]  DEF_IR_GPIO_DATA   = 4'b0010;
   localparam logic [3:0]  DEF_IR_GPIO_CONFIG = 4'b0011;
   localparam logic [3:0]  DEF_IR_BYPASS      = 4'b1111;
   localparam logic [31:0] DEF_IDCODE_VALUE   = 32'h1000_0001;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine with Moore decode of the capture/shift/update
// states used by the controller and the GPIO scan chain.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic tck,
   input  logic reset_,
   input  logic tms,
   output logic test_logic_reset,
   output logic capture_ir,
   output logic shift_ir,
   output logic update_ir,
   output logic capture_dr,
   output logic shift_dr,
   output logic update_dr
);

   tap_state_e state;
   tap_state_e state_nxt;

   always_ff @(posedge tck) begin
      if (!reset_) state <= TEST_LOGIC_RESET;
      else         state <= state_nxt;
   end

   // Next-state on tms and state decode strobes.
   always_comb begin
      state_nxt        = state;
      test_logic_reset = 1'b0;
      capture_ir       = 1'b0;
      shift_ir         = 1'b0;
      update_ir        = 1'b0;
      capture_dr       = 1'b0;
      shift_dr         = 1'b0;
      update_dr        = 1'b0;

      case (state)
         TEST_LOGIC_RESET: state_nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    state_nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
         SELECT_DR:        state_nxt = tms ? SELECT_IR        : CAPTURE_DR;
         CAPTURE_DR:       state_nxt = tms ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         state_nxt = tms ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         state_nxt = tms ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         state_nxt = tms ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         state_nxt = tms ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        state_nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
         SELECT_IR:        state_nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       state_nxt = tms ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         state_nxt = tms ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         state_nxt = tms ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         state_nxt = tms ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         state_nxt = tms ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        state_nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
         default:          state_nxt = TEST_LOGIC_RESET;
      endcase

      test_logic_reset = (state == TEST_LOGIC_RESET);
      capture_ir       = (state == CAPTURE_IR);
      shift_ir         = (state == SHIFT_IR);
      update_ir        = (state == UPDATE_IR);
      capture_dr       = (state == CAPTURE_DR);
      shift_dr         = (state == SHIFT_DR);
      update_dr        = (state == UPDATE_DR);
   end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller for the GPIO scan chain: instruction register, IDCODE and
// BYPASS data registers, instruction decode and the tdo mux.
module jtag_tap_ctrl
   import jtag_pkg::*;
#(
   parameter int unsigned        IR_BITS        = DEF_IR_BITS,
   parameter logic [31:0]        IDCODE_VALUE   = DEF_IDCODE_VALUE,
   parameter logic [IR_BITS-1:0] IR_IDCODE      = IR_BITS'(DEF_IR_IDCODE),
   parameter logic [IR_BITS-1:0] IR_GPIO_DATA   = IR_BITS'(DEF_IR_GPIO_DATA),
   parameter logic [IR_BITS-1:0] IR_GPIO_CONFIG = IR_BITS'(DEF_IR_GPIO_CONFIG),
   parameter logic [IR_BITS-1:0] IR_BYPASS      = IR_BITS'(DEF_IR_BYPASS)
) (
   input  logic               tck,
   input  logic               reset_,
   input  logic               tms,
   input  logic               tdi,
   output logic               tdo,
   output logic               tdo_ena,
   output logic               capture_dr,
   output logic               shift_dr,
   output logic               update_dr,
   output logic               gpio_data_ir,
   output logic               gpio_config_ir,
   input  logic               gpios_tdo,
   output logic [IR_BITS-1:0] ir_value
);

   logic               test_logic_reset;
   logic               capture_ir;
   logic               shift_ir;
   logic               update_ir;

   logic [IR_BITS-1:0] ir;
   logic [IR_BITS-1:0] ir_shift;
   logic [31:0]        idcode_sr;
   logic               bypass_reg;

   logic               sel_idcode;
   logic               sel_gpio;

   jtag_tap_fsm u_fsm (
      .tck              (tck),
      .reset_           (reset_),
      .tms              (tms),
      .test_logic_reset (test_logic_reset),
      .capture_ir       (capture_ir),
      .shift_ir         (shift_ir),
      .update_ir        (update_ir),
      .capture_dr       (capture_dr),
      .shift_dr         (shift_dr),
      .update_dr        (update_dr)
   );

   // Instruction register and its shift stage.
   always_ff @(posedge tck) begin
      if (!reset_) begin
         ir       <= IR_IDCODE;
         ir_shift <= '0;
      end else begin
         if (test_logic_reset) ir <= IR_IDCODE;
         else if (update_ir)   ir <= ir_shift;

         if (capture_ir)    ir_shift <= IR_BITS'(1);
         else if (shift_ir) ir_shift <= {tdi, ir_shift[IR_BITS-1:1]};
      end
   end

   // IDCODE and BYPASS data registers; GPIO chains capture/shift themselves.
   always_ff @(posedge tck) begin
      if (!reset_) begin
         idcode_sr  <= IDCODE_VALUE;
         bypass_reg <= 1'b0;
      end else begin
         if (sel_idcode) begin
            if (capture_dr)    idcode_sr <= IDCODE_VALUE;
            else if (shift_dr) idcode_sr <= {tdi, idcode_sr[31:1]};
         end
         if (!sel_idcode && !sel_gpio) begin
            if (capture_dr)    bypass_reg <= 1'b0;
            else if (shift_dr) bypass_reg <= tdi;
         end
      end
   end

   // Decode depends only on the IR; unknown codes fall through to BYPASS.
   always_comb begin
      sel_idcode     = (ir == IR_IDCODE);
      gpio_data_ir   = (ir == IR_GPIO_DATA);
      gpio_config_ir = (ir == IR_GPIO_CONFIG);
      sel_gpio       = gpio_data_ir || gpio_config_ir;
      ir_value       = ir;
      tdo_ena        = shift_ir || shift_dr;
   end

   always_comb begin
      tdo = 1'b0;
      if (shift_ir)        tdo = ir_shift[0];
      else if (shift_dr) begin
         if (sel_gpio)        tdo = gpios_tdo;
         else if (sel_idcode) tdo = idcode_sr[0];
         else                 tdo = bypass_reg;
      end
   end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed self-checking bench for jtag_tap_ctrl.
module tb_jtag_tap_ctrl;
   import jtag_pkg::*;

   logic       tck = 1'b0;
   logic       reset_ = 1'b0;
   logic       tms = 1'b1;
   logic       tdi = 1'b0;
   logic       gpios_tdo = 1'b0;
   logic       tdo;
   logic       tdo_ena;
   logic       capture_dr;
   logic       shift_dr;
   logic       update_dr;
   logic       gpio_data_ir;
   logic       gpio_config_ir;
   logic [3:0] ir_value;

   int n_checks = 0;
   int n_fail   = 0;

   logic cnt_en = 1'b0;
   int   cap_cnt = 0;
   int   sh_cnt  = 0;
   int   upd_cnt = 0;

   logic [31:0] q;

   jtag_tap_ctrl dut (
      .tck            (tck),
      .reset_         (reset_),
      .tms            (tms),
      .tdi            (tdi),
      .tdo            (tdo),
      .tdo_ena        (tdo_ena),
      .capture_dr     (capture_dr),
      .shift_dr       (shift_dr),
      .update_dr      (update_dr),
      .gpio_data_ir   (gpio_data_ir),
      .gpio_config_ir (gpio_config_ir),
      .gpios_tdo      (gpios_tdo),
      .ir_value       (ir_value)
   );

   always #5 tck = ~tck;

   // Strobe activity counters, sampled mid-cycle.
   always @(negedge tck) begin
      if (!cnt_en) begin
         cap_cnt <= 0;
         sh_cnt  <= 0;
         upd_cnt <= 0;
      end else begin
         cap_cnt <= cap_cnt + int'(capture_dr);
         sh_cnt  <= sh_cnt  + int'(shift_dr);
         upd_cnt <= upd_cnt + int'(update_dr);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input logic tms_v, input logic tdi_v);
      tms = tms_v;
      tdi = tdi_v;
      @(posedge tck);
      #1;
   endtask

   // Shift n bits LSB first starting in a SHIFT state; last bit leaves with tms=1.
   task automatic shift_bits(input int n, input logic [31:0] d, input logic [31:0] g,
                             output logic [31:0] r);
      r = '0;
      for (int i = 0; i < n; i++) begin
         tdi       = d[i];
         gpios_tdo = g[i];
         tms       = (i == n - 1);
         #1;
         r[i] = tdo;
         @(posedge tck);
         #1;
      end
   endtask

   task automatic goto_shift_dr();
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   task automatic goto_shift_ir();
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   task automatic load_ir(input logic [3:0] code);
      logic [31:0] r;
      goto_shift_ir();
      shift_bits(4, 32'(code), 32'h0, r);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
   endtask

   initial begin
      // Power-on reset
      reset_ = 1'b0;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      check_eq("rst_state",   32'(dut.u_fsm.state), 32'(TEST_LOGIC_RESET));
      check_eq("rst_tdo",     32'(tdo), 32'h0);
      check_eq("rst_tdo_ena", 32'(tdo_ena), 32'h0);
      check_eq("rst_strobes", 32'({capture_dr, shift_dr, update_dr}), 32'h0);
      check_eq("rst_gpio_ir", 32'({gpio_data_ir, gpio_config_ir}), 32'h0);
      check_eq("rst_ir",      32'(ir_value), 32'h1);
      reset_ = 1'b1;
      tick(1'b0, 1'b0);

      // IDCODE read
      goto_shift_dr();
      check_eq("idc_tdo_ena", 32'(tdo_ena), 32'h1);
      shift_bits(32, 32'h0, 32'h0, q);
      check_eq("idcode", q, 32'h1000_0001);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);

      // IR load of GPIO_DATA; captured 01 pattern comes out first
      goto_shift_ir();
      shift_bits(4, 32'h2, 32'h0, q);
      check_eq("ir_capture", q, 32'h1);
      tick(1'b1, 1'b0);
      check_eq("ir_in_update", 32'(ir_value), 32'h1);
      check_eq("gdata_in_update", 32'(gpio_data_ir), 32'h0);
      tick(1'b0, 1'b0);
      check_eq("ir_gdata", 32'(ir_value), 32'h2);
      check_eq("gdata_sel", 32'({gpio_data_ir, gpio_config_ir}), 32'h2);

      // GPIO data scan: tdo follows gpios_tdo, one strobe pulse each
      cnt_en = 1'b1;
      goto_shift_dr();
      shift_bits(6, 32'h0, 32'h2D, q);
      check_eq("gpio_tdo", q, 32'h2D);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      cnt_en = 1'b0;
      check_eq("cap_cnt", 32'(cap_cnt), 32'd1);
      check_eq("sh_cnt",  32'(sh_cnt),  32'd6);
      check_eq("upd_cnt", 32'(upd_cnt), 32'd1);

      // Synchronous reset mid SHIFT_DR
      goto_shift_dr();
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      check_eq("pre_rst_shift", 32'(shift_dr), 32'h1);
      reset_ = 1'b0;
      tick(1'b0, 1'b0);
      reset_ = 1'b1;
      check_eq("mid_rst_state",   32'(dut.u_fsm.state), 32'(TEST_LOGIC_RESET));
      check_eq("mid_rst_ir",      32'(ir_value), 32'h1);
      check_eq("mid_rst_strobes", 32'({capture_dr, shift_dr, update_dr}), 32'h0);
      check_eq("mid_rst_tdo_ena", 32'(tdo_ena), 32'h0);
      check_eq("mid_rst_gpio_ir", 32'({gpio_data_ir, gpio_config_ir}), 32'h0);

      // TMS reset from SHIFT_IR: five tms=1 reach TLR, IR forced back to IDCODE
      tick(1'b0, 1'b0);
      goto_shift_ir();
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      check_eq("tms_rst_state", 32'(dut.u_fsm.state), 32'(TEST_LOGIC_RESET));
      tick(1'b1, 1'b0);
      check_eq("tms_rst_ir", 32'(ir_value), 32'h1);

      // Bypass with an undefined code
      tick(1'b0, 1'b0);
      load_ir(4'b0101);
      check_eq("ir_undef", 32'(ir_value), 32'h5);
      check_eq("undef_gpio_ir", 32'({gpio_data_ir, gpio_config_ir}), 32'h0);
      goto_shift_dr();
      shift_bits(9, 32'h0A5, 32'h1FF, q);
      check_eq("bypass", q, 32'h14A);
      check_eq("bypass_gpio_ir", 32'({gpio_data_ir, gpio_config_ir}), 32'h0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);

      // GPIO_CONFIG scan with a PAUSE_DR excursion
      load_ir(4'b0011);
      check_eq("gcfg_sel", 32'({gpio_data_ir, gpio_config_ir}), 32'h1);
      cnt_en = 1'b1;
      goto_shift_dr();
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      check_eq("sh_exit1", 32'(shift_dr), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0);
         check_eq("sh_pause", 32'(shift_dr), 32'h0);
      end
      tick(1'b1, 1'b0);
      check_eq("sh_exit2", 32'(shift_dr), 32'h0);
      tick(1'b0, 1'b0);
      check_eq("sh_resume", 32'(shift_dr), 32'h1);
      tick(1'b1, 1'b0);
      check_eq("sh_exit1b", 32'(shift_dr), 32'h0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      cnt_en = 1'b0;
      check_eq("pause_sh_cnt",  32'(sh_cnt),  32'd4);
      check_eq("pause_cap_cnt", 32'(cap_cnt), 32'd1);
      check_eq("pause_upd_cnt", 32'(upd_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jtag_tap_ctrl.md
# jtag_tap_ctrl

IEEE 1149.1 TAP controller that sequences the GPIO scan chain. It tracks the 16-state TAP FSM from `tms`, holds the instruction register, and owns the IDCODE and BYPASS data registers. It decodes the active instruction into the `gpio_data_ir`/`gpio_config_ir` selects and drives `capture_dr`/`shift_dr`/`update_dr` to the GPIO block. It muxes the selected register's serial output onto `tdo`, and sits between the JTAG pins and the GPIO scan-chain block.

## Interface
Parameters:
- `IR_BITS`, 4: instruction register width, ≥2.
- `IDCODE_VALUE`, 32'h1000_0001: IDCODE register contents; bit 0 must be 1.
- `IR_IDCODE`, 4'b0001: selects IDCODE DR.
- `IR_GPIO_DATA`, 4'b0010: selects GPIO data chain.
- `IR_GPIO_CONFIG`, 4'b0011: selects GPIO output-enable chain.
- `IR_BYPASS`, 4'b1111: selects BYPASS. All undefined codes also select BYPASS.

Ports:
- `tck` in 1: the only clock; all state updates on posedge.
- `reset_` in 1: synchronous, active-low reset.
- `tms` in 1: mode select.
- `tdi` in 1: serial data in.
- `tdo` out 1: serial data out.
- `tdo_ena` out 1: high in SHIFT_IR/SHIFT_DR.
- `capture_dr`, `shift_dr`, `update_dr` out 1 each: high while the FSM is in the state of the same name.
- `gpio_data_ir`, `gpio_config_ir` out 1 each: one-hot decode of the current IR.
- `gpios_tdo` in 1: serial output of the GPIO chain.
- `ir_value` out IR_BITS: current instruction, for debug.

## Operation
- **FSM states:** TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, and the same seven-state sequence for IR.
- **Transitions:** standard 1149.1 on `tms` at each posedge. TEST_LOGIC_RESET is reached from any state by five consecutive `tms`=1.
- **Reset:** `reset_`=0 at a posedge forces the following, overriding any in-flight scan:
  - state = TEST_LOGIC_RESET;
  - IR = IR_IDCODE;
  - IR shift register = 0;
  - bypass = 0;
  - IDCODE shift register = IDCODE_VALUE.
- **Reset values of outputs:** `tdo`=0, `tdo_ena`=0, all DR strobes 0, `gpio_*_ir`=0, `ir_value`=IR_IDCODE.
- **In TEST_LOGIC_RESET:** IR is also forced to IR_IDCODE, with no `reset_` needed.
- **CAPTURE_IR:** IR shift register loads {0…0,01}.
- **SHIFT_IR:** IR shift register shifts right; `tdi` enters the MSB.
- **UPDATE_IR:** IR takes the IR shift register contents at the posedge that leaves UPDATE_IR.
- **CAPTURE_DR:**
  - IDCODE selected: IDCODE shift register loads IDCODE_VALUE.
  - BYPASS selected: bypass loads 0.
  - GPIO instructions: the GPIO block does its own capture.
- **SHIFT_DR:** the selected internal register shifts right; `tdi` enters the MSB (bypass is 1 bit wide).
- **Instruction decode:**
  - Instruction selects are combinational from IR only. They never depend on FSM state.
  - Any code not matching IDCODE, GPIO_DATA or GPIO_CONFIG behaves as BYPASS.
- **`tdo` mux (combinational):**
  - SHIFT_IR: IR shift register bit 0.
  - SHIFT_DR with GPIO_DATA or GPIO_CONFIG: `gpios_tdo`.
  - SHIFT_DR with IDCODE: IDCODE shift register bit 0.
  - SHIFT_DR with BYPASS: bypass.
  - Otherwise: 0.
- **PAUSE and EXIT states:** hold all shift registers unchanged.

## Timing
- The strobes are Moore outputs of the state register. They are valid one `tck` after the transition into the state, and the downstream block acts on them at the posedge that exits the state.
- An IR change becomes visible on `gpio_*_ir` in the cycle after UPDATE_IR, i.e. in RUN_TEST_IDLE or SELECT_DR.
- `tdo` reflects the current bit during each SHIFT cycle. The first bit out is the captured LSB.
- A scan of N DR bits in SHIFT_DR takes N posedges; the last bit is shifted on the posedge leaving SHIFT_DR with `tms`=1.
- No pipeline: zero extra latency on any path.

## Structure
- Shared package `jtag_pkg` contains:
  - the TAP state enum, 4-bit encoding, as localparams;
  - default instruction codes;
  - IDCODE default.
- One sub-module: `jtag_tap_fsm`, containing only the state register, the next-state logic and the state-decode strobes. The IR, data registers and `tdo` mux live in `jtag_tap_ctrl`.

## Test plan
- **Reset:** hold `reset_`=0 for 1 cycle mid-SHIFT_DR → state TEST_LOGIC_RESET, `ir_value`=4'b0001, all strobes 0, `tdo_ena`=0.
- **TMS reset:** from SHIFT_IR, drive `tms`=1 for 5 cycles → TEST_LOGIC_RESET, IR=IDCODE.
- **IDCODE read:** after reset, go to SHIFT_DR and shift 32 bits → `tdo` stream equals 32'h1000_0001, LSB first.
- **IR load:** shift 4'b0010 into IR → captured bits read out on `tdo` are 1,0,0,0. After UPDATE_IR, `gpio_data_ir`=1, `gpio_config_ir`=0, and CAPTURE/SHIFT/UPDATE_DR strobes each pulse exactly once per scan.
- **Bypass:** load IR 4'b0101 (undefined) and shift 8'hA5 through DR → `tdo` returns 0 followed by 8'hA5 delayed one bit; both GPIO selects stay 0.
- **Pause:** during a GPIO_CONFIG DR scan, enter PAUSE_DR for 3 cycles, then resume → `shift_dr` is low during PAUSE and EXIT, and the total `shift_dr`-high count equals the bits shifted.
